// File: rtl/face_match_if.sv
// Signal bundle between face_match_sched and its Xillybus FIFOs, compare engine and result FIFO.
// The master modport is the scheduler side.
interface face_match_if #(
    parameter int unsigned CNT_W = 16
);
    logic [31:0]      a_data;
    logic [31:0]      b_data;
    logic             a_empty;
    logic             b_empty;
    logic             a_rden;
    logic             b_rden;
    logic             a_open;
    logic             b_open;
    logic             res_open;
    logic             eng_valid;
    logic             eng_ready;
    logic [31:0]      eng_a;
    logic [31:0]      eng_b;
    logic             eng_first;
    logic             eng_last;
    logic             eng_abort;
    logic             eng_res_valid;
    logic [31:0]      eng_res;
    logic             res_full;
    logic             res_wren;
    logic [31:0]      res_data;
    logic             res_eof;
    logic [CNT_W-1:0] vec_count;
    logic             err_partial;
    logic             busy;

    modport master (
        input  a_data, b_data, a_empty, b_empty, a_open, b_open, res_open,
               eng_ready, eng_res_valid, eng_res, res_full,
        output a_rden, b_rden, eng_valid, eng_a, eng_b, eng_first, eng_last,
               eng_abort, res_wren, res_data, res_eof, vec_count, err_partial, busy
    );

    modport slave (
        output a_data, b_data, a_empty, b_empty, a_open, b_open, res_open,
               eng_ready, eng_res_valid, eng_res, res_full,
        input  a_rden, b_rden, eng_valid, eng_a, eng_b, eng_first, eng_last,
               eng_abort, res_wren, res_data, res_eof, vec_count, err_partial, busy
    );
endinterface

// File: rtl/face_match_sched.sv
// Pops (probe, candidate) word pairs in lockstep from two non-FWFT FIFOs, feeds them to the
// compare engine one vector at a time and pushes one result word per vector.
module face_match_sched #(
    parameter int unsigned VEC_LEN = 128,
    parameter int unsigned CNT_W   = 16
) (
    input  logic          bus_clk,
    input  logic          bus_rst,
    face_match_if.master  bus
);
    localparam int unsigned IDX_W = $clog2(VEC_LEN);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(VEC_LEN - 1);

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        CAPT,
        ISSUE,
        WAIT_RES,
        PUSH
    } state_t;

    state_t           state;
    state_t           state_d;
    logic [IDX_W-1:0] word_idx;
    logic [IDX_W-1:0] idx_d;
    logic             armed;
    logic             res_open_q;

    logic both_open;
    logic rden_c;
    logic capt_c;
    logic hs_c;
    logic abort_c;
    logic latch_c;
    logic wren_c;
    logic res_rise;
    logic res_fall;

    assign both_open = bus.a_open && bus.b_open;
    assign res_rise  = bus.res_open && !res_open_q;
    assign res_fall  = !bus.res_open && res_open_q;

    // The FIFOs are non-FWFT, so the read strobe must be issued in FETCH itself for the
    // word to be on a_data/b_data during CAPT.
    assign bus.a_rden = rden_c;
    assign bus.b_rden = rden_c;

    always_ff @(posedge bus_clk) begin
        if (bus_rst) begin
            state    <= IDLE;
            word_idx <= '0;
        end else begin
            state    <= state_d;
            word_idx <= idx_d;
        end
    end

    always_comb begin
        state_d = state;
        idx_d   = word_idx;
        rden_c  = 1'b0;
        capt_c  = 1'b0;
        hs_c    = 1'b0;
        abort_c = 1'b0;
        latch_c = 1'b0;
        wren_c  = 1'b0;
        case (state)
            IDLE: begin
                if (both_open) begin
                    state_d = FETCH;
                end
            end
            FETCH: begin
                // A close only takes effect here, between pairs.
                if (!both_open) begin
                    abort_c = (word_idx != '0);
                    idx_d   = '0;
                    state_d = IDLE;
                end else if (!bus.a_empty && !bus.b_empty) begin
                    rden_c  = 1'b1;
                    state_d = CAPT;
                end
            end
            CAPT: begin
                capt_c  = 1'b1;
                state_d = ISSUE;
            end
            ISSUE: begin
                if (bus.eng_ready) begin
                    hs_c = 1'b1;
                    if (word_idx == LAST_IDX) begin
                        idx_d   = '0;
                        state_d = WAIT_RES;
                    end else begin
                        idx_d   = word_idx + IDX_W'(1);
                        state_d = FETCH;
                    end
                end
            end
            WAIT_RES: begin
                if (bus.eng_res_valid) begin
                    latch_c = 1'b1;
                    state_d = PUSH;
                end
            end
            PUSH: begin
                if (!bus.res_open) begin
                    state_d = IDLE;
                end else if (!bus.res_full) begin
                    wren_c  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge bus_clk) begin
        if (bus_rst) begin
            bus.eng_valid   <= 1'b0;
            bus.eng_a       <= '0;
            bus.eng_b       <= '0;
            bus.eng_first   <= 1'b0;
            bus.eng_last    <= 1'b0;
            bus.eng_abort   <= 1'b0;
            bus.res_wren    <= 1'b0;
            bus.res_data    <= '0;
            bus.res_eof     <= 1'b0;
            bus.vec_count   <= '0;
            bus.err_partial <= 1'b0;
            bus.busy        <= 1'b0;
            armed           <= 1'b0;
            res_open_q      <= 1'b0;
        end else begin
            res_open_q    <= bus.res_open;
            bus.busy      <= (state_d != IDLE);
            bus.eng_abort <= abort_c;
            bus.res_wren  <= wren_c;

            if (capt_c) begin
                bus.eng_a     <= bus.a_data;
                bus.eng_b     <= bus.b_data;
                bus.eng_first <= (word_idx == '0);
                bus.eng_last  <= (word_idx == LAST_IDX);
                bus.eng_valid <= 1'b1;
            end else if (hs_c) begin
                bus.eng_valid <= 1'b0;
            end

            if (latch_c) begin
                bus.res_data <= bus.eng_res;
            end
            if (wren_c) begin
                bus.vec_count <= bus.vec_count + CNT_W'(1);
            end

            // A reopen of the result stream starts a fresh error window.
            if (res_rise) begin
                bus.err_partial <= 1'b0;
            end else if (abort_c) begin
                bus.err_partial <= 1'b1;
            end

            if (both_open) begin
                armed <= 1'b1;
            end else if (res_fall) begin
                armed <= 1'b0;
            end

            bus.res_eof <= !res_rise && armed && (state == IDLE) && !bus.a_open &&
                           !bus.b_open && bus.a_empty && bus.b_empty;
        end
    end
endmodule

// File: tb/tb_face_match_sched.sv
// Directed scoreboard bench for face_match_sched with VEC_LEN=4: FIFO and engine models,
// expected pairs/results queued by the stimulus and checked by a negedge monitor.
module tb_face_match_sched;
    localparam int unsigned VEC_LEN = 4;
    localparam int unsigned CNT_W   = 16;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic        first;
        logic        last;
    } pair_t;

    typedef struct packed {
        logic [31:0]      data;
        logic [CNT_W-1:0] cnt;
    } res_t;

    logic clk;
    logic rst;

    face_match_if #(.CNT_W(CNT_W)) bus ();

    face_match_sched #(.VEC_LEN(VEC_LEN), .CNT_W(CNT_W)) dut (
        .bus_clk (clk),
        .bus_rst (rst),
        .bus     (bus.master)
    );

    int checks = 0;
    int errors = 0;

    pair_t exp_pairs[$];
    res_t  exp_res[$];
    int    exp_cnt   = 0;
    int    abort_cnt = 0;

    logic [31:0] mem_a [64];
    logic [31:0] mem_b [64];
    int wr_a = 0;
    int wr_b = 0;
    int rd_a = 0;
    int rd_b = 0;

    int          eng_delay   = 2;
    logic [31:0] eng_res_val = 32'h0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign bus.a_empty = (wr_a == rd_a);
    assign bus.b_empty = (wr_b == rd_b);

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Non-FWFT FIFO read ports: data appears the cycle after rden.
    always @(posedge clk) begin
        if (bus.a_rden && (wr_a != rd_a)) begin
            bus.a_data <= mem_a[rd_a];
            rd_a       <= rd_a + 1;
        end
        if (bus.b_rden && (wr_b != rd_b)) begin
            bus.b_data <= mem_b[rd_b];
            rd_b       <= rd_b + 1;
        end
    end

    // Engine model: returns eng_res_val eng_delay cycles after eng_last is accepted.
    initial begin
        bus.eng_res_valid = 1'b0;
        bus.eng_res       = 32'h0;
        forever begin
            @(negedge clk);
            if (bus.eng_valid && bus.eng_ready && bus.eng_last) begin
                repeat (eng_delay) @(posedge clk);
                #1;
                bus.eng_res       = eng_res_val;
                bus.eng_res_valid = 1'b1;
                @(posedge clk);
                #1;
                bus.eng_res_valid = 1'b0;
            end
        end
    end

    // Monitor: pair handshakes, result writes, abort pulses, read strobes.
    initial begin
        pair_t p;
        res_t  r;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (bus.eng_valid && bus.eng_ready) begin
                    if (exp_pairs.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL pair_unexpected actual=%0h/%0h expected=none", bus.eng_a, bus.eng_b);
                    end else begin
                        p = exp_pairs.pop_front();
                        chk("pair_data", {bus.eng_a, bus.eng_b}, {p.a, p.b});
                        chk("pair_flags", 64'({bus.eng_first, bus.eng_last}), 64'({p.first, p.last}));
                    end
                end
                if (bus.res_wren) begin
                    if (exp_res.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL res_unexpected actual=%0h expected=none", bus.res_data);
                    end else begin
                        r = exp_res.pop_front();
                        chk("res_data", 64'(bus.res_data), 64'(r.data));
                        chk("res_count", 64'(bus.vec_count), 64'(r.cnt));
                    end
                end
                if (bus.a_rden || bus.b_rden) begin
                    chk("rden_lockstep_nonempty",
                        64'({bus.a_rden, bus.b_rden, bus.a_empty, bus.b_empty}), 64'(4'b1100));
                end
                if (bus.eng_abort) abort_cnt++;
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push_pair(input logic [31:0] a, input logic [31:0] b,
                             input logic first, input logic last);
        pair_t p;
        mem_a[wr_a] = a;
        mem_b[wr_b] = b;
        wr_a++;
        wr_b++;
        p.a = a; p.b = b; p.first = first; p.last = last;
        exp_pairs.push_back(p);
    endtask

    task automatic run_vec(input logic [31:0] base_a, input logic [31:0] base_b,
                           input logic [31:0] res_val, input bit expect_res);
        res_t r;
        eng_res_val = res_val;
        for (int i = 0; i < int'(VEC_LEN); i++) begin
            push_pair(base_a + 32'(i), base_b + 32'(i), i == 0, i == int'(VEC_LEN) - 1);
        end
        if (expect_res) begin
            exp_cnt++;
            r.data = res_val;
            r.cnt  = CNT_W'(exp_cnt);
            exp_res.push_back(r);
        end
    endtask

    task automatic wait_vec(input string name, input int n);
        int t = 0;
        while (int'(bus.vec_count) != n && t < 300) begin
            @(negedge clk);
            t++;
        end
        chk(name, 64'(bus.vec_count), 64'(n));
        step(1);
    endtask

    task automatic wait_drained(input string name);
        int t = 0;
        while (exp_pairs.size() != 0 && t < 300) begin
            @(negedge clk);
            t++;
        end
        chk(name, 64'(exp_pairs.size()), 64'(0));
        step(1);
    endtask

    initial begin
        int t;
        int bad;
        int snap_rd;
        int snap_abort;

        rst          = 1'b1;
        bus.a_open   = 1'b0;
        bus.b_open   = 1'b0;
        bus.res_open = 1'b0;
        bus.eng_ready = 1'b1;
        bus.res_full = 1'b0;
        step(3);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_eng_valid", 64'(bus.eng_valid), 64'(0));
        chk("rst_res_wren", 64'(bus.res_wren), 64'(0));
        chk("rst_res_eof", 64'(bus.res_eof), 64'(0));
        chk("rst_vec_count", 64'(bus.vec_count), 64'(0));
        chk("rst_err_partial", 64'(bus.err_partial), 64'(0));
        chk("rst_busy", 64'(bus.busy), 64'(0));
        chk("rst_eng_abort", 64'(bus.eng_abort), 64'(0));
        chk("rst_rden", 64'({bus.a_rden, bus.b_rden}), 64'(0));

        // Basic vector.
        step(1);
        bus.a_open = 1'b1;
        bus.b_open = 1'b1;
        bus.res_open = 1'b1;
        run_vec(32'd1, 32'd5, 32'hDEAD, 1'b1);
        wait_vec("vec1_count", 1);

        // Engine stall on the second pair.
        bus.eng_ready = 1'b0;
        run_vec(32'd1, 32'd5, 32'hDEAD, 1'b1);
        t = 0;
        do begin @(negedge clk); t++; end while (!bus.eng_valid && t < 50);
        chk("stall_first_valid", 64'(bus.eng_valid), 64'(1));
        step(0);
        @(posedge clk); #1;
        bus.eng_ready = 1'b1;
        @(posedge clk); #1;
        bus.eng_ready = 1'b0;
        t = 0;
        do begin @(negedge clk); t++; end while (!(bus.eng_valid && bus.eng_a == 32'd2) && t < 50);
        chk("stall_word2_a", 64'(bus.eng_a), 64'(2));
        snap_rd = rd_a;
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (!bus.eng_valid || bus.eng_a != 32'd2 || bus.eng_b != 32'd6) bad++;
        end
        chk("stall_hold_bad_cycles", 64'(bad), 64'(0));
        chk("stall_no_rden", 64'(rd_a), 64'(snap_rd));
        step(1);
        bus.eng_ready = 1'b1;
        wait_vec("vec2_count", 2);

        // Result FIFO full when the result arrives.
        bus.res_full = 1'b1;
        run_vec(32'h11, 32'h21, 32'hCAFE, 1'b1);
        t = 0;
        while (bus.res_data != 32'hCAFE && t < 100) begin @(negedge clk); t++; end
        chk("full_res_latched", 64'(bus.res_data), 64'(32'hCAFE));
        bad = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (bus.res_wren || bus.res_data != 32'hCAFE || !bus.busy) bad++;
        end
        chk("full_hold_bad_cycles", 64'(bad), 64'(0));
        chk("full_count_held", 64'(bus.vec_count), 64'(2));
        step(1);
        bus.res_full = 1'b0;
        wait_vec("vec3_count", 3);

        // Stream close after two pairs.
        snap_abort = abort_cnt;
        push_pair(32'h31, 32'h41, 1'b1, 1'b0);
        push_pair(32'h32, 32'h42, 1'b0, 1'b0);
        wait_drained("abort_pairs_drained");
        step(2);
        bus.a_open = 1'b0;
        step(5);
        @(negedge clk);
        chk("abort_pulse_count", 64'(abort_cnt - snap_abort), 64'(1));
        chk("abort_err_partial", 64'(bus.err_partial), 64'(1));
        chk("abort_no_result", 64'(bus.vec_count), 64'(3));
        chk("abort_idle", 64'(bus.busy), 64'(0));
        step(1);
        bus.a_open = 1'b1;
        run_vec(32'h51, 32'h61, 32'hD00D, 1'b1);
        wait_vec("vec4_count", 4);

        // EOF once both writers close with FIFOs drained.
        snap_abort = abort_cnt;
        bus.a_open = 1'b0;
        bus.b_open = 1'b0;
        t = 0;
        do begin @(negedge clk); t++; end while (!bus.res_eof && t < 4);
        chk("eof_asserted", 64'(bus.res_eof), 64'(1));
        chk("eof_err_sticky", 64'(bus.err_partial), 64'(1));
        chk("eof_no_abort", 64'(abort_cnt - snap_abort), 64'(0));
        step(1);
        bus.res_open = 1'b0;
        step(3);
        @(negedge clk);
        chk("eof_cleared_by_close", 64'(bus.res_eof), 64'(0));
        step(1);
        bus.res_open = 1'b1;
        step(3);
        @(negedge clk);
        chk("reopen_eof", 64'(bus.res_eof), 64'(0));
        chk("reopen_err_cleared", 64'(bus.err_partial), 64'(0));

        // Reset while waiting for the engine result; the late result must be ignored.
        step(1);
        bus.a_open = 1'b1;
        bus.b_open = 1'b1;
        eng_delay = 10;
        run_vec(32'h71, 32'h81, 32'hBAD0, 1'b0);
        wait_drained("rst_pairs_drained");
        step(1);
        chk("wait_res_busy", 64'(bus.busy), 64'(1));
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("mid_rst_outputs",
            64'({bus.eng_valid, bus.res_wren, bus.res_eof, bus.err_partial,
                 bus.busy, bus.eng_abort, bus.eng_first, bus.eng_last}), 64'(0));
        chk("mid_rst_vec_count", 64'(bus.vec_count), 64'(0));
        chk("mid_rst_res_data", 64'(bus.res_data), 64'(0));
        step(15);
        @(negedge clk);
        chk("late_res_count", 64'(bus.vec_count), 64'(0));
        chk("late_res_data", 64'(bus.res_data), 64'(0));
        chk("late_res_busy", 64'(bus.busy), 64'(1));
        chk("late_res_queue", 64'(exp_res.size()), 64'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
